bch_decoder_arbiter: RTL

BCH_DECODER_ARBITER -- requirements
Module: bch_decoder_arbiter

---
 rtl/bch_pkg.sv | 11 +
 rtl/bch_rr_pick.sv | 36 +++
 rtl/bch_decoder_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// Shared constants and state encoding for the BCH(63,51) decoder arbiter.
package bch_pkg;
  localparam int CW_LEN  = 63;
  localparam int MSG_LEN = 51;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } t_arb_state;
endpackage

// File: rtl/bch_rr_pick.sv
// Combinational grant picker. Round-robin from last_i+1 by default;
// BCH_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores last_i.
module bch_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int GW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [GW-1:0]     last_i,
  output logic [GW-1:0]     pick_o,
  output logic              any_o
);
  assign any_o = |req_i;

`ifdef BCH_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    pick_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req_i[i]) pick_o = GW'(i);
  end
`else
  logic [GW-1:0] idx;

  // Walk from farthest to nearest so the closest requester after last_i wins.
  always_comb begin
    pick_o = '0;
    idx    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = GW'((int'(last_i) + 1 + k) % NUM_CH);
      if (req_i[idx]) pick_o = idx;
    end
  end
`endif
endmodule

// File: rtl/bch_decoder_arbiter.sv
// Arbitrates NUM_CH serial codeword requesters onto one shared BCH(63,51) decoder.
// Define BCH_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module bch_decoder_arbiter
  import bch_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 6,
  localparam int GW    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [NUM_CH-1:0] req_data,
  output logic [NUM_CH-1:0] req_ready,
  output logic [NUM_CH-1:0] resp_valid,
  output logic [NUM_CH-1:0] resp_data,
  input  logic [NUM_CH-1:0] resp_ready,
  output logic              dec_in_valid,
  output logic              dec_in_data,
  input  logic              dec_in_ready,
  input  logic              dec_out_valid,
  input  logic              dec_out_data,
  output logic              dec_out_ready,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              frame_done
);
  t_arb_state       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic [GW-1:0]    pick;
  logic             any_req;

  bch_rr_pick #(.NUM_CH(NUM_CH), .GW(GW)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= GW'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // All datapath steering is combinational off the locked grant.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    last_d        = last_q;
    req_ready     = '0;
    resp_valid    = '0;
    resp_data     = '0;
    dec_in_valid  = 1'b0;
    dec_in_data   = 1'b0;
    dec_out_ready = 1'b0;
    frame_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        dec_in_valid       = req_valid[grant_q];
        dec_in_data        = req_data[grant_q];
        req_ready[grant_q] = dec_in_ready;
        if (req_valid[grant_q] && dec_in_ready) begin
          if (cnt_q == CNT_W'(CW_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        resp_valid[grant_q] = dec_out_valid;
        resp_data[grant_q]  = dec_out_data;
        dec_out_ready       = resp_ready[grant_q];
        if (dec_out_valid && resp_ready[grant_q]) begin
          if (cnt_q == CNT_W'(MSG_LEN - 1)) begin
            frame_done = 1'b1;
            last_d     = grant_q;
            cnt_d      = '0;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule
